// File: rtl/branch_seq_pkg.sv
// State encoding for the branch sequencer FSM.
package branch_seq_pkg;
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FLAGS = 2'd1,
    ISSUE      = 2'd2
  } state_t;
endpackage

// File: rtl/cond_mod_pkg.sv
// Shared condition-code definitions used by every stage that decodes
// or evaluates branch conditions.
package Cond_Mod;
  localparam int COND_WIRENUM = 3;

  localparam logic [COND_WIRENUM-1:0] COND_NOP = 3'd0;
  localparam logic [COND_WIRENUM-1:0] COND_L   = 3'd1;
  localparam logic [COND_WIRENUM-1:0] COND_G   = 3'd2;
  localparam logic [COND_WIRENUM-1:0] COND_E   = 3'd3;
  localparam logic [COND_WIRENUM-1:0] COND_NE  = 3'd4;
  localparam logic [COND_WIRENUM-1:0] COND_LE  = 3'd5;
  localparam logic [COND_WIRENUM-1:0] COND_GE  = 3'd6;
endpackage

// File: rtl/cond_eval.sv
// Combinational evaluation of a condition code against ALU compare flags.
module cond_eval
  import Cond_Mod::*;
(
  input  logic [COND_WIRENUM-1:0] cond,
  input  logic                    lt,
  input  logic                    eq,
  input  logic                    gt,
  output logic                    taken
);
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_L:  taken = lt;
      COND_G:  taken = gt;
      COND_E:  taken = eq;
      COND_NE: taken = !eq;
      COND_LE: taken = lt | eq;
      COND_GE: taken = gt | eq;
      default: taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/branch_sequencer.sv
// Accepts branches/jumps from decode, waits for compare flags, and issues
// a redirect plus one-cycle flush to fetch; keeps taken/not-taken counters.
module branch_sequencer
  import Cond_Mod::*;
  import branch_seq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    br_valid,
  output logic                    br_ready,
  input  logic                    br_is_jump,
  input  logic [COND_WIRENUM-1:0] br_cond,
  input  logic [31:0]             br_target,
  input  logic                    flag_valid,
  input  logic                    flag_lt,
  input  logic                    flag_eq,
  input  logic                    flag_gt,
  input  logic                    kill,
  output logic                    redir_valid,
  input  logic                    redir_ready,
  output logic [31:0]             redir_pc,
  output logic                    flush,
  output logic [CNT_W-1:0]        taken_cnt,
  output logic [CNT_W-1:0]        ntaken_cnt
);
  state_t                  state, state_next;
  logic [COND_WIRENUM-1:0] cond_reg;
  logic                    is_jump_reg;
  logic [31:0]             target_reg;
  logic                    flush_reg, flush_next;
  logic                    accept, cond_taken, taken;
  logic                    inc_taken, inc_ntaken;

  cond_eval u_cond_eval (
    .cond  (cond_reg),
    .lt    (flag_lt),
    .eq    (flag_eq),
    .gt    (flag_gt),
    .taken (cond_taken)
  );

  assign accept = (state == IDLE) && br_valid && !kill;
  assign taken  = cond_taken | is_jump_reg;

  always_comb begin
    state_next = state;
    flush_next = 1'b0;
    inc_taken  = 1'b0;
    inc_ntaken = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (br_is_jump) begin
            state_next = ISSUE;
            inc_taken  = 1'b1;
          end else if (br_cond != COND_NOP) begin
            state_next = WAIT_FLAGS;
          end
        end
      end
      WAIT_FLAGS: begin
        if (kill) begin
          state_next = IDLE;
        end else if (flag_valid) begin
          if (taken) begin
            state_next = ISSUE;
            inc_taken  = 1'b1;
          end else begin
            state_next = IDLE;
            inc_ntaken = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (kill) begin
          state_next = IDLE;
        end else if (redir_ready) begin
          state_next = IDLE;
          flush_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      flush_reg   <= 1'b0;
      cond_reg    <= '0;
      is_jump_reg <= 1'b0;
      target_reg  <= '0;
    end else begin
      state     <= state_next;
      flush_reg <= flush_next;
      if (accept) begin
        cond_reg    <= br_cond;
        is_jump_reg <= br_is_jump;
        target_reg  <= br_target;
      end
    end
  end

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt  <= '0;
      ntaken_cnt <= '0;
    end else begin
      if (inc_taken && (taken_cnt != '1))
        taken_cnt <= taken_cnt + CNT_W'(1);
      if (inc_ntaken && (ntaken_cnt != '1))
        ntaken_cnt <= ntaken_cnt + CNT_W'(1);
    end
  end

  assign br_ready    = (state == IDLE);
  assign redir_valid = (state == ISSUE);
  assign redir_pc    = redir_valid ? target_reg : 32'h0;
  assign flush       = flush_reg;
endmodule

// File: tb/tb_branch_sequencer.sv
// Directed self-checking bench for branch_sequencer.
module tb_branch_sequencer;
  import Cond_Mod::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br_valid, br_is_jump;
  logic [2:0]  br_cond;
  logic [31:0] br_target;
  logic        flag_valid, flag_lt, flag_eq, flag_gt;
  logic        kill, redir_ready;
  logic        br_ready, redir_valid, flush;
  logic [31:0] redir_pc;
  logic [15:0] taken_cnt, ntaken_cnt;
  logic        s_br_ready, s_redir_valid, s_flush;
  logic [31:0] s_redir_pc;
  logic [3:0]  s_taken_cnt, s_ntaken_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_taken  = 16'd0;
  logic [15:0] exp_ntaken = 16'd0;

  always #5 clk = ~clk;

  branch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready),
    .br_is_jump(br_is_jump), .br_cond(br_cond), .br_target(br_target),
    .flag_valid(flag_valid), .flag_lt(flag_lt), .flag_eq(flag_eq),
    .flag_gt(flag_gt), .kill(kill), .redir_valid(redir_valid),
    .redir_ready(redir_ready), .redir_pc(redir_pc), .flush(flush),
    .taken_cnt(taken_cnt), .ntaken_cnt(ntaken_cnt)
  );

  // Narrow-counter copy so saturation is reachable in a short run.
  branch_sequencer #(.CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(s_br_ready),
    .br_is_jump(br_is_jump), .br_cond(br_cond), .br_target(br_target),
    .flag_valid(flag_valid), .flag_lt(flag_lt), .flag_eq(flag_eq),
    .flag_gt(flag_gt), .kill(kill), .redir_valid(s_redir_valid),
    .redir_ready(redir_ready), .redir_pc(s_redir_pc), .flush(s_flush),
    .taken_cnt(s_taken_cnt), .ntaken_cnt(s_ntaken_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag);
    check({tag, ".taken_cnt"}, {16'h0, taken_cnt}, {16'h0, exp_taken});
    check({tag, ".ntaken_cnt"}, {16'h0, ntaken_cnt}, {16'h0, exp_ntaken});
  endtask

  // Accept a conditional branch, deliver flags 'gap' cycles later, check outcome.
  task automatic run_branch(input string tag, input logic [2:0] cond,
                            input logic lt, input logic eq, input logic gt,
                            input logic exp_tk, input logic [31:0] target, input int gap);
    br_valid = 1'b1; br_is_jump = 1'b0; br_cond = cond; br_target = target;
    flag_valid = 1'b1; flag_lt = ~lt; flag_eq = ~eq; flag_gt = ~gt;
    step();
    br_valid = 1'b0; flag_valid = 1'b0;
    check({tag, ".wait_br_ready"}, {31'h0, br_ready}, 32'h0);
    repeat (gap - 1) step();
    check({tag, ".wait_no_redir"}, {31'h0, redir_valid}, 32'h0);
    flag_valid = 1'b1; flag_lt = lt; flag_eq = eq; flag_gt = gt;
    step();
    flag_valid = 1'b0; flag_lt = 1'b0; flag_eq = 1'b0; flag_gt = 1'b0;
    check({tag, ".redir_valid"}, {31'h0, redir_valid}, {31'h0, exp_tk});
    if (exp_tk) begin
      exp_taken++;
      check({tag, ".redir_pc"}, redir_pc, target);
      redir_ready = 1'b1;
      step();
      redir_ready = 1'b0;
      check({tag, ".flush"}, {31'h0, flush}, 32'h1);
    end else begin
      exp_ntaken++;
      check({tag, ".br_ready"}, {31'h0, br_ready}, 32'h1);
      check({tag, ".redir_pc_zero"}, redir_pc, 32'h0);
      step();
      check({tag, ".no_flush"}, {31'h0, flush}, 32'h0);
    end
    check_counts(tag);
  endtask

  typedef struct {
    logic [2:0] cond;
    logic lt, eq, gt, tk;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{COND_GE, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{COND_LE, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{COND_LE, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{COND_NE, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{COND_NE, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{COND_G,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{COND_L,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{3'd7,    1'b1, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0; br_valid = 1'b0; br_is_jump = 1'b0; br_cond = COND_NOP;
    br_target = 32'h0; flag_valid = 1'b0; flag_lt = 1'b0; flag_eq = 1'b0;
    flag_gt = 1'b0; kill = 1'b0; redir_ready = 1'b0;
    #2;
    check("rst.br_ready", {31'h0, br_ready}, 32'h1);
    check("rst.redir_valid", {31'h0, redir_valid}, 32'h0);
    check("rst.redir_pc", redir_pc, 32'h0);
    check("rst.flush", {31'h0, flush}, 32'h0);
    check_counts("rst");
    step(); step();
    rst_n = 1'b1;
    step();

    // Jump with fetch already ready.
    br_valid = 1'b1; br_is_jump = 1'b1; br_target = 32'h0000_1000; redir_ready = 1'b1;
    check("jmp.accept_ready", {31'h0, br_ready}, 32'h1);
    step();
    br_valid = 1'b0; br_is_jump = 1'b0;
    exp_taken++;
    check("jmp.redir_valid", {31'h0, redir_valid}, 32'h1);
    check("jmp.redir_pc", redir_pc, 32'h0000_1000);
    check("jmp.br_ready_busy", {31'h0, br_ready}, 32'h0);
    check_counts("jmp");
    step();
    redir_ready = 1'b0;
    check("jmp.flush", {31'h0, flush}, 32'h1);
    check("jmp.flush_br_ready", {31'h0, br_ready}, 32'h1);
    check("jmp.redir_dropped", {31'h0, redir_valid}, 32'h0);
    step();
    check("jmp.flush_one_cycle", {31'h0, flush}, 32'h0);

    run_branch("beq_taken", COND_E, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_2000, 3);
    run_branch("beq_ntaken", COND_E, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_2004, 3);

    // COND_NOP branch is swallowed in IDLE.
    br_valid = 1'b1; br_cond = COND_NOP; br_target = 32'h0000_2100;
    step();
    br_valid = 1'b0;
    check("nop.br_ready", {31'h0, br_ready}, 32'h1);
    check("nop.redir_valid", {31'h0, redir_valid}, 32'h0);
    check_counts("nop");

    // Fetch stalls redirect for five cycles.
    br_valid = 1'b1; br_is_jump = 1'b1; br_target = 32'h0000_3000;
    step();
    br_valid = 1'b0; br_is_jump = 1'b0;
    exp_taken++;
    for (int i = 0; i < 5; i++) begin
      check("stall.redir_valid", {31'h0, redir_valid}, 32'h1);
      check("stall.redir_pc", redir_pc, 32'h0000_3000);
      check("stall.br_ready", {31'h0, br_ready}, 32'h0);
      step();
    end
    redir_ready = 1'b1;
    step();
    redir_ready = 1'b0;
    check("stall.flush", {31'h0, flush}, 32'h1);
    check_counts("stall");
    step();

    // kill wins over a taken flag_valid in WAIT_FLAGS.
    br_valid = 1'b1; br_cond = COND_L; br_target = 32'h0000_4000;
    step();
    br_valid = 1'b0;
    step();
    flag_valid = 1'b1; flag_lt = 1'b1; kill = 1'b1;
    step();
    flag_valid = 1'b0; flag_lt = 1'b0; kill = 1'b0;
    check("kwait.br_ready", {31'h0, br_ready}, 32'h1);
    check("kwait.redir_valid", {31'h0, redir_valid}, 32'h0);
    check("kwait.flush", {31'h0, flush}, 32'h0);
    check_counts("kwait");
    step();
    check("kwait.no_late_flush", {31'h0, flush}, 32'h0);

    // kill blocks acceptance in IDLE.
    br_valid = 1'b1; br_is_jump = 1'b1; br_target = 32'h0000_4100; kill = 1'b1;
    step();
    br_valid = 1'b0; br_is_jump = 1'b0; kill = 1'b0;
    check("kidle.redir_valid", {31'h0, redir_valid}, 32'h0);
    check_counts("kidle");

    // kill wins over redir_ready in ISSUE; committed count stays.
    br_valid = 1'b1; br_is_jump = 1'b1; br_target = 32'h0000_5000;
    step();
    br_valid = 1'b0; br_is_jump = 1'b0;
    exp_taken++;
    kill = 1'b1; redir_ready = 1'b1;
    step();
    kill = 1'b0; redir_ready = 1'b0;
    check("kissue.redir_valid", {31'h0, redir_valid}, 32'h0);
    check("kissue.flush", {31'h0, flush}, 32'h0);
    check_counts("kissue");

    for (int i = 0; i < 8; i++)
      run_branch($sformatf("vec%0d", i), vecs[i].cond, vecs[i].lt, vecs[i].eq,
                 vecs[i].gt, vecs[i].tk, 32'h0000_6000 + 32'(i * 4), 1);

    // Back-to-back jumps push the 4-bit counter past its ceiling.
    redir_ready = 1'b1; br_is_jump = 1'b1; br_target = 32'h0000_7000;
    for (int i = 0; i < 16; i++) begin
      br_valid = 1'b1;
      step();
      br_valid = 1'b0;
      step();
      exp_taken++;
    end
    redir_ready = 1'b0; br_is_jump = 1'b0;
    check("sat.small_taken", {28'h0, s_taken_cnt}, 32'hF);
    check("sat.small_ntaken", {28'h0, s_ntaken_cnt}, {28'h0, exp_ntaken[3:0]});
    check_counts("sat");

    // Asynchronous reset during ISSUE.
    br_valid = 1'b1; br_is_jump = 1'b1; br_target = 32'h0000_8000;
    step();
    br_valid = 1'b0; br_is_jump = 1'b0;
    check("arst.pre_valid", {31'h0, redir_valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst.redir_valid", {31'h0, redir_valid}, 32'h0);
    check("arst.redir_pc", redir_pc, 32'h0);
    check("arst.flush", {31'h0, flush}, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    exp_taken = 16'd0; exp_ntaken = 16'd0;
    check("arst.br_ready", {31'h0, br_ready}, 32'h1);
    check("arst.no_flush", {31'h0, flush}, 32'h0);
    check_counts("arst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_sequencer.md
BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL be reset by these ports only.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 br_valid  in  1  decode presents a branch or jump.
REQ-005 br_ready  out  1  sequencer can accept; high only in IDLE.
REQ-006 br_is_jump  in  1  1 means jump (unconditional), 0 means conditional branch.
REQ-007 br_cond  in  COND_WIRENUM  condition code from the branch/jump decoder.
REQ-008 br_target  in  32  resolved target PC.
REQ-009 flag_valid  in  1  ALU compare flags valid this cycle.
REQ-010 flag_lt, flag_eq, flag_gt  in  1 each  ALU compare result.
REQ-011 kill  in  1  pipeline-wide flush (exception); aborts any operation in progress.
REQ-012 redir_valid  out  1  redirect request to fetch.
REQ-013 redir_ready  in  1  fetch accepts redirect.
REQ-014 redir_pc  out  32  redirect target.
REQ-015 flush  out  1  one-cycle pulse telling younger stages to squash.
REQ-016 taken_cnt, ntaken_cnt  out  16 each  saturating performance counters.

Function
REQ-017 FSM states SHALL be IDLE, WAIT_FLAGS and ISSUE.
REQ-018 In IDLE, br_valid & br_ready SHALL capture br_cond, br_is_jump and br_target.
- jump: go to ISSUE.
- branch with cond = COND_NOP: stay in IDLE, no redirect, no count.
- other branch: go to WAIT_FLAGS.
REQ-019 In WAIT_FLAGS, flags SHALL be sampled only when flag_valid = 1; flag_valid in the accept cycle SHALL be ignored.
REQ-020 Taken evaluation SHALL be: COND_L = lt; COND_G = gt; COND_E = eq; COND_NE = !eq; COND_LE = lt|eq; COND_GE = gt|eq; any other code = not taken.
REQ-021 Branch resolution:
- taken: increment taken_cnt and go to ISSUE.
- not taken: increment ntaken_cnt and return to IDLE with no redirect and no flush.
REQ-022 A jump SHALL increment taken_cnt when it enters ISSUE.
REQ-023 In ISSUE, redir_valid SHALL be 1 and redir_pc SHALL equal the captured target; both SHALL hold stable until redir_ready = 1.
REQ-024 On redir_valid & redir_ready, the block SHALL pulse flush for exactly the next cycle and return to IDLE; br_ready SHALL be 1 in that same next cycle.
REQ-025 Latency:
- jump accepted in cycle N: redir_valid in cycle N+1.
- flag_valid in WAIT_FLAGS in cycle M (taken): redir_valid in cycle M+1.
REQ-026 When redir_ready is already 1, the block SHALL still hold redir_valid for one full cycle.
REQ-027 Counters SHALL saturate at 16'hFFFF and never wrap.
REQ-028 kill = 1 in any state SHALL force IDLE on the next edge.
- No redirect and no flush pulse are issued.
- A counter increment already committed is retained.
- kill takes priority over a simultaneous flag_valid or redir_ready.
REQ-029 kill and br_valid in the same IDLE cycle: the branch SHALL NOT be accepted.
REQ-030 redir_pc SHALL be 32'h0 whenever redir_valid = 0.

Reset
REQ-031 While rst_n = 0:
- state = IDLE, br_ready = 1;
- redir_valid = 0, redir_pc = 0, flush = 0;
- taken_cnt = 0, ntaken_cnt = 0;
- captured registers = 0.
REQ-032 Reset asserted mid-operation (WAIT_FLAGS or ISSUE) SHALL drop redir_valid immediately (asynchronously), with no flush pulse.

Structure
REQ-033 Condition constants and COND_WIRENUM SHALL come from the shared Cond_Mod definitions and SHALL NOT be redefined locally.
REQ-034 The FSM state enum SHALL live in a shared package, branch_seq_pkg.
REQ-035 Flag-versus-condition evaluation SHALL be a combinational sub-module, cond_eval (cond, lt, eq, gt -> taken), reusable by other stages.

Verification
REQ-036 Jump: br_is_jump = 1, target 32'h0000_1000, redir_ready = 1 -> redir_valid one cycle later, redir_pc = 32'h1000, flush pulse next cycle, taken_cnt = 1.
REQ-037 Branch COND_E, flags arrive 3 cycles later with eq = 1 -> redir_valid the cycle after flag_valid; with eq = 0 -> no redirect, ntaken_cnt = 1.
REQ-038 redir_ready held 0 for 5 cycles in ISSUE -> redir_valid and redir_pc stable for all 5 cycles, br_ready = 0 throughout.
REQ-039 kill asserted in WAIT_FLAGS together with flag_valid, taken condition -> IDLE next cycle, no redir_valid, no flush, counters unchanged.
REQ-040 Counter saturation: preload taken_cnt to 16'hFFFF via 65535 taken jumps, then one more jump -> taken_cnt stays 16'hFFFF.
REQ-041 rst_n pulled low during ISSUE -> redir_valid = 0 before the next clk edge; after release br_ready = 1 and all counters = 0.
